miss_response_scheduler: RTL and testbench

Tracks outstanding cache misses and returns each miss address as a one-cycle fill response after its programmed latency. Sits directly downstream of the cache latency emulator: it accepts miss addresses tagged with their per-address latency and drives the emulator's `addr_response` / `addr_response_valid` fill inputs. It holds up to ENTRIES misses in flight, each with its own countdown, and retires at most one per cycle.

---
 rtl/miss_response_scheduler_if.sv | 28 ++
 rtl/miss_response_scheduler.sv | 130 +++++++++++++
 tb/tb_miss_response_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miss_response_scheduler_if.sv
// Miss request / fill response bundle between the latency emulator and the miss scheduler.
// master = requester (emulator side), slave = scheduler.
interface miss_response_scheduler_if #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 27,
    parameter int LAT_W   = 5
);
    localparam int OUT_W = $clog2(ENTRIES + 1);

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [LAT_W-1:0]  req_latency;
    logic              req_ready;
    logic              addr_response_valid;
    logic [ADDR_W-1:0] addr_response;
    logic [OUT_W-1:0]  outstanding;
    logic              merge_hit;

    modport master (
        output req_valid, req_addr, req_latency,
        input  req_ready, addr_response_valid, addr_response, outstanding, merge_hit
    );

    modport slave (
        input  req_valid, req_addr, req_latency,
        output req_ready, addr_response_valid, addr_response, outstanding, merge_hit
    );
endinterface

// File: rtl/miss_response_scheduler.sv
// Holds up to ENTRIES misses, each counting down its latency; retires one per cycle as a registered fill pulse
// (accept at T, latency L -> response after edge T+L+1). req_ready drops when full; MSHR_MERGE_EN enables address merging.
module miss_response_scheduler #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 27,
    parameter int LAT_W   = 5
) (
    input  logic                      clk,
    input  logic                      resetb,
    miss_response_scheduler_if.slave  bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int OUT_W = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0] ent_valid;
    logic [ADDR_W-1:0]  ent_addr [ENTRIES];
    logic [LAT_W-1:0]   ent_cnt  [ENTRIES];

    logic [ENTRIES-1:0] eligible;
    logic               ret_any;
    logic [IDX_W-1:0]   ret_idx;
    logic               free_any;
    logic [IDX_W-1:0]   free_idx;
    logic               merge_any;
    logic               accept;
    logic               do_alloc;

    logic               resp_vld_q;
    logic [ADDR_W-1:0]  resp_addr_q;
    logic [OUT_W-1:0]   out_q;
    logic               merge_q;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            eligible[i] = ent_valid[i] && (ent_cnt[i] == '0);
        end
    end

    // Scanning from the top down leaves the lowest matching index in each selector.
    always_comb begin
        ret_any  = 1'b0;
        ret_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                ret_any = 1'b1;
                ret_idx = IDX_W'(i);
            end
            if (!ent_valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef MSHR_MERGE_EN
    logic [ENTRIES-1:0] match;

    // An entry leaving at this edge cannot absorb a new request; that one allocates instead.
    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = ent_valid[i] && (ent_addr[i] == bus.req_addr) &&
                       !(ret_any && (ret_idx == IDX_W'(i)));
        end
    end

    assign merge_any = |match;
`else
    assign merge_any = 1'b0;
`endif

    assign bus.req_ready = free_any || merge_any;
    assign accept        = bus.req_valid && bus.req_ready;
    assign do_alloc      = accept && !merge_any;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ent_valid   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_addr[i] <= '0;
                ent_cnt[i]  <= '0;
            end
            resp_vld_q  <= 1'b0;
            resp_addr_q <= '0;
            out_q       <= '0;
            merge_q     <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (ret_any && (ret_idx == IDX_W'(i))) begin
                    ent_valid[i] <= 1'b0;
                end else if (ent_valid[i] && (ent_cnt[i] != '0)) begin
                    ent_cnt[i] <= ent_cnt[i] - LAT_W'(1);
                end
                // The free slot is never the retiring one, so load and clear cannot collide.
                if (do_alloc && (free_idx == IDX_W'(i))) begin
                    ent_valid[i] <= 1'b1;
                    ent_addr[i]  <= bus.req_addr;
                    ent_cnt[i]   <= bus.req_latency;
                end
            end

            resp_vld_q <= ret_any;
            if (ret_any) begin
                resp_addr_q <= ent_addr[ret_idx];
            end

            case ({do_alloc, ret_any})
                2'b10:   out_q <= out_q + OUT_W'(1);
                2'b01:   out_q <= out_q - OUT_W'(1);
                default: out_q <= out_q;
            endcase

            merge_q <= accept && merge_any;
        end
    end

    assign bus.addr_response_valid = resp_vld_q;
    assign bus.addr_response       = resp_addr_q;
    assign bus.outstanding         = out_q;
    assign bus.merge_hit           = merge_q;

    a_out_matches_valid: assert property (@(posedge clk) disable iff (!resetb)
        out_q == OUT_W'($countones(ent_valid)));

    a_out_bounded: assert property (@(posedge clk) disable iff (!resetb)
        int'(out_q) <= ENTRIES);
endmodule

// File: tb/tb_miss_response_scheduler.sv
// Scoreboard bench: a deadline-based reference model queues expected fills; a monitor checks every cycle.
module tb_miss_response_scheduler;
    localparam int ENTRIES = 8;
    localparam int ADDR_W  = 27;
    localparam int LAT_W   = 5;

    logic clk    = 1'b0;
    logic resetb = 1'b0;

    miss_response_scheduler_if #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .LAT_W(LAT_W)) bus ();

    miss_response_scheduler #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .LAT_W(LAT_W)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                at;
    } exp_t;

    exp_t              exp_q[$];
    bit                m_valid [ENTRIES];
    logic [ADDR_W-1:0] m_addr  [ENTRIES];
    int                m_due   [ENTRIES];
    logic [ADDR_W-1:0] m_last_addr = '0;
    bit                m_merge = 1'b0;
    int                cyc = 0;
    int                acc_cnt = 0;
    int                acc_edge = 0;

    int                checks = 0;
    int                errors = 0;
    int                resp_seen = 0;
    int                merge_seen = 0;
    int                max_out = 0;
    logic [ADDR_W-1:0] obs_addr[$];
    int                obs_at[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < ENTRIES; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    // Ready for the upcoming edge: a free slot, or (with merging) a live match not leaving at that edge.
    function automatic bit m_ready();
        int r = -1;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (m_valid[i] && m_due[i] <= cyc + 1) r = i;
        for (int i = 0; i < ENTRIES; i++)
            if (!m_valid[i]) return 1'b1;
`ifdef MSHR_MERGE_EN
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_addr[i] == bus.req_addr && i != r) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Reference model: each miss carries the edge number from which it may retire (accept edge + L + 1).
    initial forever begin
        @(posedge clk or negedge resetb);
        if (!resetb) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            exp_q.delete();
            m_last_addr = '0;
            m_merge     = 1'b0;
        end else begin
            int ret, fr, mt;
            cyc++;
            ret = -1; fr = -1; mt = -1;
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (m_valid[i] && m_due[i] <= cyc) ret = i;
                if (!m_valid[i]) fr = i;
            end
`ifdef MSHR_MERGE_EN
            for (int i = 0; i < ENTRIES; i++)
                if (m_valid[i] && m_addr[i] == bus.req_addr && i != ret) mt = i;
`endif
            m_merge = 1'b0;
            if (bus.req_valid && (fr >= 0 || mt >= 0)) begin
                acc_cnt++;
                acc_edge = cyc;
                if (mt >= 0) begin
                    m_merge = 1'b1;
                end else begin
                    m_valid[fr] = 1'b1;
                    m_addr[fr]  = bus.req_addr;
                    m_due[fr]   = cyc + int'(bus.req_latency) + 1;
                end
            end
            if (ret >= 0) begin
                exp_q.push_back('{addr: m_addr[ret], at: cyc});
                m_last_addr  = m_addr[ret];
                m_valid[ret] = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs against the model once per cycle, mid-cycle.
    initial forever begin
        bit exp_now;
        @(negedge clk);
        #1;
        exp_now = (exp_q.size() > 0) && (exp_q[0].at == cyc);
        check("resp_valid", bus.addr_response_valid, exp_now);
        if (exp_now) begin
            if (bus.addr_response_valid) check("resp_addr", bus.addr_response, exp_q[0].addr);
            void'(exp_q.pop_front());
        end
        if (bus.addr_response_valid) begin
            resp_seen++;
            obs_addr.push_back(bus.addr_response);
            obs_at.push_back(cyc);
        end
        check("resp_addr_hold", bus.addr_response, m_last_addr);
        check("outstanding", bus.outstanding, m_count());
        check("merge_hit", bus.merge_hit, m_merge);
        check("req_ready", bus.req_ready, m_ready());
        if (bus.merge_hit) merge_seen++;
        if (int'(bus.outstanding) > max_out) max_out = int'(bus.outstanding);
    end

    task automatic issue(input logic [ADDR_W-1:0] a, input int lat);
        int n0 = acc_cnt;
        bus.req_valid   = 1'b1;
        bus.req_addr    = a;
        bus.req_latency = LAT_W'(lat);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (acc_cnt != n0) break;
        end
        check("issue_accept", acc_cnt != n0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_resp(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #2;
            if (resp_seen >= target) break;
        end
        check("resp_arrived", resp_seen >= target, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #2;
            if (m_count() == 0 && exp_q.size() == 0) break;
        end
        check("drain_outstanding", bus.outstanding, 0);
    endtask

    initial begin
        int n0, m0, t0, hits;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.req_latency = '0;
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);

        // Single miss, L=3: fill after edge T+4.
        n0 = resp_seen;
        issue(27'h05, 3);
        t0 = acc_edge;
        wait_resp(n0 + 1, 30);
        if (resp_seen > n0) begin
            check("single_lat", obs_at[n0] - t0, 4);
            check("single_addr", obs_addr[n0], 27'h05);
        end
        drain();

        // Zero latency: fill after the next edge.
        n0 = resp_seen;
        issue(27'h11, 0);
        t0 = acc_edge;
        wait_resp(n0 + 1, 30);
        if (resp_seen > n0) begin
            check("zero_lat", obs_at[n0] - t0, 1);
            check("zero_addr", obs_addr[n0], 27'h11);
        end
        drain();

        // Contention: both eligible together, lower index first.
        n0 = resp_seen;
        issue(27'h01, 2);
        t0 = acc_edge;
        issue(27'h02, 1);
        wait_resp(n0 + 2, 30);
        if (resp_seen > n0 + 1) begin
            check("cont_first_addr", obs_addr[n0], 27'h01);
            check("cont_first_at", obs_at[n0] - t0, 3);
            check("cont_second_addr", obs_addr[n0 + 1], 27'h02);
            check("cont_second_at", obs_at[n0 + 1] - t0, 4);
        end
        drain();

        // Full: 8 long misses, then a held request waits for the first retire.
        max_out = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            issue(27'h100 + ADDR_W'(i), 31);
            if (i == 0) t0 = acc_edge;
        end
        bus.req_valid   = 1'b1;
        bus.req_addr    = 27'h200;
        bus.req_latency = LAT_W'(1);
        #1;
        check("full_ready_low", bus.req_ready, 0);
        check("full_outstanding", bus.outstanding, ENTRIES);
        issue(27'h200, 1);
        check("full_accept_edge", acc_edge - t0, 33);
        drain();
        check("full_max_out", max_out, ENTRIES);

        // Same address twice: merged when enabled, duplicated otherwise.
        n0 = resp_seen;
        m0 = merge_seen;
        issue(27'h20, 10);
        t0 = acc_edge;
        issue(27'h20, 2);
        idle(20);
        drain();
        hits = 0;
        for (int i = n0; i < resp_seen; i++) if (obs_addr[i] == 27'h20) hits++;
`ifdef MSHR_MERGE_EN
        check("merge_resp_count", hits, 1);
        check("merge_pulses", merge_seen - m0, 1);
        if (resp_seen > n0) check("merge_resp_at", obs_at[n0] - t0, 11);
`else
        check("dup_resp_count", hits, 2);
        check("dup_merge_pulses", merge_seen - m0, 0);
        if (resp_seen > n0) check("dup_first_at", obs_at[n0] - t0, 4);
`endif

        // Reset mid-flight: in-flight misses vanish without responses.
        issue(27'h31, 20);
        issue(27'h32, 20);
        issue(27'h33, 20);
        check("rst_pre_out", bus.outstanding, 3);
        resetb = 1'b0;
        #1;
        check("rst_out_zero", bus.outstanding, 0);
        check("rst_addr_zero", bus.addr_response, 0);
        @(negedge clk);
        resetb = 1'b1;
        n0 = resp_seen;
        idle(40);
        check("rst_no_resp", resp_seen, n0);

        // Randomized traffic from a small address pool to provoke duplicates and contention.
        for (int k = 0; k < 400; k++) begin
            int lat;
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
            issue(27'h40 + ADDR_W'($urandom_range(0, 11)), lat);
        end
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
